// File: rtl/kyber_cs_register_pkg.sv
// Shared constants for the Kyber control/status register bank:
// address map, controller state and mode encodings, widths, version word.
package kyber_cs_register_pkg;

   localparam int DW = 32;
   localparam int AW = 12;

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] word_t;

   localparam addr_t ADDR_START   = 12'd0;
   localparam addr_t ADDR_RESTART = 12'd1;
   localparam addr_t ADDR_MODE    = 12'd2;
   localparam addr_t ADDR_STATE   = 12'd3;
   localparam addr_t ADDR_CNT     = 12'd4;
   localparam addr_t ADDR_RDDATA  = 12'd5;
   localparam addr_t ADDR_WRDATA  = 12'd6;
   localparam addr_t ADDR_PK_OUT  = 12'd7;
   localparam addr_t ADDR_SK_OUT  = 12'd8;
   localparam addr_t ADDR_C_OUT   = 12'd9;
   localparam addr_t ADDR_M_OUT   = 12'd10;
   localparam addr_t ADDR_BUSY    = 12'd11;
   localparam addr_t ADDR_VERSION = 12'd12;
   localparam addr_t ADDR_SCRATCH = 12'd13;

   localparam word_t VERSION = 32'h4B59_0001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_PROCESS = 2'd2,
      ST_OUTPUT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_KEYGEN = 2'd0,
      MODE_ENCAPS = 2'd1,
      MODE_DECAPS = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // Replace only the byte lanes whose enable is set.
   function automatic word_t merge_bytes(
      input word_t      old_w,
      input word_t      new_w,
      input logic [3:0] lanes
   );
      word_t r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/kyber_cs_register_if.sv
// Host BRAM-style bus: en/addr/we/wrdata toward the register bank,
// registered rddata back. master = host side, slave = register bank.
interface kyber_cs_register_if;
   import kyber_cs_register_pkg::*;

   logic       en;
   addr_t      addr;
   logic [3:0] we;
   word_t      wrdata;
   word_t      rddata;

   modport master (
      output en,
      output addr,
      output we,
      output wrdata,
      input  rddata
   );

   modport slave (
      input  en,
      input  addr,
      input  we,
      input  wrdata,
      output rddata
   );

endinterface

// File: rtl/kyber_cs_register_pulse_gen.sv
// cs_pulse_gen: registered one-cycle strobe.
// Ports: clk, rst (sync, active-low), fire (qualified write), pulse.
module cs_pulse_gen (
   input  logic clk,
   input  logic rst,
   input  logic fire,
   output logic pulse
);

   logic pulse_q;
   logic pulse_d;

   // Follows fire each cycle, so it self-clears when no new write arrives.
   always_comb begin
      pulse_d = fire;
   end

   always_ff @(posedge clk) begin
      if (!rst) pulse_q <= 1'b0;
      else      pulse_q <= pulse_d;
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/kyber_cs_register.sv
// Kyber control/status register bank: host bus in, strobes/mode out.
// Ports: clk, rst (sync, active-low), bus (slave), core status in, strobes/mode out.
module kyber_cs_register
   import kyber_cs_register_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   kyber_cs_register_if.slave   bus,
   input  logic [1:0]           current_state,
   input  logic [9:0]           cnt,
   input  word_t                rddata_reg,
   input  word_t                wrdata_reg,
   input  word_t                pk_out_reg,
   input  word_t                sk_out_reg,
   input  word_t                c_out_reg,
   input  word_t                m_out_reg,
   output logic                 start_pulse,
   output logic                 restart_pulse,
   output logic [1:0]           mode
);

   logic       wr_acc;
   logic       rd_acc;
   logic       start_fire;
   logic       restart_fire;

   logic [1:0] mode_q;
   logic [1:0] mode_d;
   word_t      scratch_q;
   word_t      scratch_d;
   word_t      rddata_q;
   word_t      rddata_d;
   word_t      rd_mux;

   assign wr_acc = bus.en && (bus.we != 4'b0000);
   assign rd_acc = bus.en && (bus.we == 4'b0000);

   // Strobe needs lane 0 enabled and a 1 in bit 0.
   assign start_fire = wr_acc
                    && (bus.addr == ADDR_START)
                    && bus.we[0]
                    && bus.wrdata[0];

   assign restart_fire = wr_acc
                      && (bus.addr == ADDR_RESTART)
                      && bus.we[0]
                      && bus.wrdata[0];

   cs_pulse_gen u_start (
      .clk   (clk),
      .rst   (rst),
      .fire  (start_fire),
      .pulse (start_pulse)
   );

   cs_pulse_gen u_restart (
      .clk   (clk),
      .rst   (rst),
      .fire  (restart_fire),
      .pulse (restart_pulse)
   );

   always_comb begin
      mode_d = mode_q;
      if (wr_acc && (bus.addr == ADDR_MODE) && bus.we[0]) begin
         mode_d = bus.wrdata[1:0];
      end
   end

   always_comb begin
      scratch_d = scratch_q;
      if (wr_acc && (bus.addr == ADDR_SCRATCH)) begin
         scratch_d = merge_bytes(scratch_q, bus.wrdata, bus.we);
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (bus.addr)
         ADDR_MODE:    rd_mux = {30'b0, mode_q};
         ADDR_STATE:   rd_mux = {30'b0, current_state};
         ADDR_CNT:     rd_mux = {22'b0, cnt};
         ADDR_RDDATA:  rd_mux = rddata_reg;
         ADDR_WRDATA:  rd_mux = wrdata_reg;
         ADDR_PK_OUT:  rd_mux = pk_out_reg;
         ADDR_SK_OUT:  rd_mux = sk_out_reg;
         ADDR_C_OUT:   rd_mux = c_out_reg;
         ADDR_M_OUT:   rd_mux = m_out_reg;
         ADDR_BUSY:    rd_mux = {31'b0, current_state != ST_IDLE};
         ADDR_VERSION: rd_mux = VERSION;
         ADDR_SCRATCH: rd_mux = scratch_q;
         default:      rd_mux = '0;
      endcase
   end

   // Output register only reloads on reads; writes leave it untouched.
   always_comb begin
      rddata_d = rddata_q;
      if (rd_acc) rddata_d = rd_mux;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q    <= 2'b00;
         scratch_q <= '0;
         rddata_q  <= '0;
      end else begin
         mode_q    <= mode_d;
         scratch_q <= scratch_d;
         rddata_q  <= rddata_d;
      end
   end

   assign mode       = mode_q;
   assign bus.rddata = rddata_q;

endmodule

// File: tb/tb_kyber_cs_register.sv
// Scoreboard bench for kyber_cs_register: driver pushes expected
// outputs per cycle, monitor pops and compares after each clock edge.
module tb_kyber_cs_register;
   import kyber_cs_register_pkg::*;

   typedef struct {
      logic [31:0] rd;
      logic        sp;
      logic        rp;
      logic [1:0]  md;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cur_state;
   logic [9:0]  cnt;
   logic [31:0] mir [6];
   logic        start_pulse;
   logic        restart_pulse;
   logic [1:0]  mode;

   logic [1:0]  nxt_state;
   logic [9:0]  nxt_cnt;
   logic [31:0] nxt_mir [6];

   logic [1:0]  m_mode;
   logic [31:0] m_scr;
   logic [31:0] m_rd;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   kyber_cs_register_if bus ();

   kyber_cs_register dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .current_state (cur_state),
      .cnt           (cnt),
      .rddata_reg    (mir[0]),
      .wrdata_reg    (mir[1]),
      .pk_out_reg    (mir[2]),
      .sk_out_reg    (mir[3]),
      .c_out_reg     (mir[4]),
      .m_out_reg     (mir[5]),
      .start_pulse   (start_pulse),
      .restart_pulse (restart_pulse),
      .mode          (mode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_read(input int a);
      if (a == 2)             return 32'(m_mode);
      if (a == 3)             return 32'(nxt_state);
      if (a == 4)             return 32'(nxt_cnt);
      if (a >= 5 && a <= 10)  return nxt_mir[a-5];
      if (a == 11)            return (nxt_state != 2'd0) ? 32'd1 : 32'd0;
      if (a == 12)            return 32'h4B59_0001;
      if (a == 13)            return m_scr;
      return 32'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at negedge, predict what the next edge produces.
   task automatic cyc(input logic r, input logic e, input int a,
                      input logic [3:0] w, input logic [31:0] d);
      exp_t x;
      @(negedge clk);
      rst        = r;
      bus.en     = e;
      bus.addr   = 12'(a);
      bus.we     = w;
      bus.wrdata = d;
      cur_state  = nxt_state;
      cnt        = nxt_cnt;
      for (int i = 0; i < 6; i++) mir[i] = nxt_mir[i];
      x.sp = 1'b0;
      x.rp = 1'b0;
      if (!r) begin
         m_mode = 2'd0;
         m_scr  = 32'h0;
         m_rd   = 32'h0;
      end else if (e && w == 4'h0) begin
         m_rd = ref_read(a);
      end else if (e) begin
         x.sp = (a == 0) && w[0] && d[0];
         x.rp = (a == 1) && w[0] && d[0];
         if (a == 2 && w[0]) m_mode = d[1:0];
         if (a == 13) begin
            for (int i = 0; i < 4; i++)
               if (w[i]) m_scr[8*i +: 8] = d[8*i +: 8];
         end
      end
      x.rd = m_rd;
      x.md = m_mode;
      sb.push_back(x);
   endtask

   task automatic rd(input int a);
      cyc(1'b1, 1'b1, a, 4'h0, 32'($urandom));
   endtask

   task automatic wr(input int a, input logic [3:0] w,
                     input logic [31:0] d);
      cyc(1'b1, 1'b1, a, w, d);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("rddata", bus.rddata, x.rd);
         chk("start_pulse", 32'(start_pulse), 32'(x.sp));
         chk("restart_pulse", 32'(restart_pulse), 32'(x.rp));
         chk("mode", 32'(mode), 32'(x.md));
      end
   end

   initial begin
      int r;
      int a;
      logic [3:0] w;
      rst = 1'b0;
      bus.en = 1'b0;
      bus.addr = '0;
      bus.we = '0;
      bus.wrdata = '0;
      nxt_state = 2'd0;
      nxt_cnt = 10'd0;
      for (int i = 0; i < 6; i++) nxt_mir[i] = 32'h1000_0000 * (i + 1);
      cur_state = 2'd0;
      cnt = 10'd0;
      for (int i = 0; i < 6; i++) mir[i] = 32'h0;
      m_mode = 2'd0;
      m_scr = 32'h0;
      m_rd = 32'h0;

      // reset wins over a start write
      cyc(1'b0, 1'b1, 0, 4'hF, 32'h1);
      cyc(1'b0, 1'b1, 0, 4'hF, 32'h1);

      // strobes
      wr(0, 4'hF, 32'h1);
      wr(1, 4'hF, 32'h1);
      cyc(1'b1, 1'b0, 0, 4'h0, 32'h0);
      wr(0, 4'hF, 32'h0);
      wr(0, 4'hE, 32'h1);
      wr(0, 4'hF, 32'h1);
      wr(0, 4'hF, 32'h1);
      cyc(1'b1, 1'b0, 0, 4'hF, 32'h1);

      // mode
      wr(2, 4'hF, 32'h2);
      rd(2);
      wr(2, 4'hE, 32'h3);
      rd(2);

      // status mirrors
      nxt_state = 2'd2;
      nxt_cnt = 10'd55;
      nxt_mir[2] = 32'h3333_2222;
      nxt_mir[5] = 32'h9ABC_DEF0;
      rd(3);
      rd(4);
      rd(7);
      rd(10);
      rd(11);
      for (int s = 0; s < 4; s++) begin
         nxt_state = 2'(s);
         rd(3);
      end

      // read-only and unmapped
      wr(3, 4'hF, 32'hDEAD_BEEF);
      wr(100, 4'hF, 32'hDEAD_BEEF);
      rd(14);
      rd(100);
      rd(12);
      rd(2);

      // scratch byte lanes
      wr(13, 4'hF, 32'hAABB_CCDD);
      wr(13, 4'h5, 32'h1122_3344);
      rd(13);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            nxt_state = 2'($urandom);
            nxt_cnt = 10'($urandom);
            for (int i = 0; i < 6; i++) nxt_mir[i] = $urandom;
         end
         r = $urandom_range(0, 9);
         if (r < 7)       a = $urandom_range(0, 15);
         else if (r == 7) a = 100;
         else             a = int'(12'($urandom));
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 4) != 0),
             a, w, $urandom);
      end

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kyber_cs_register.md
# kyber_cs_register

Control/status register bank for the Kyber accelerator, sitting between the host-side memory-mapped bus (BRAM-style port: en/addr/we/wrdata/rddata) and the core controller. Host writes produce one-cycle start/restart strobes and a persistent operating mode. Reads return the controller state, the word counter and the core's data/result words.

## Interface
Parameters: none. Address map and constants live in the shared package.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- en  in  1  bus access enable
- addr  in  12  word index (not byte address)
- we  in  4  byte-lane write enables; lane i covers wrdata[8i+7:8i]
- wrdata  in  32  write data
- rddata  out  32  registered read data
- current_state  in  2  controller state: 0 IDLE, 1 LOAD, 2 PROCESS, 3 OUTPUT
- cnt  in  10  controller word counter
- rddata_reg, wrdata_reg, pk_out_reg, sk_out_reg, c_out_reg, m_out_reg  in  32 each  core data words (read-only mirrors)
- start_pulse  out  1  one-cycle start strobe
- restart_pulse  out  1  one-cycle restart strobe
- mode  out  2  operating mode (0 keygen, 1 encaps, 2 decaps, 3 reserved)

## Operation
- Write access: en=1 and we≠0. Read access: en=1 and we=0. en=0: no effect; outputs hold (strobes still self-clear).
- Full 12-bit address decode; no aliasing.
- Address map (R=read, W=write):
  - 0 START (W): wrdata[0]=1 with we[0]=1 → start_pulse. Reads 0.
  - 1 RESTART (W): wrdata[0]=1 with we[0]=1 → restart_pulse. Reads 0.
  - 2 MODE (R/W): we[0]=1 loads mode ← wrdata[1:0]; reads {30'b0, mode}.
  - 3 STATE (R): {30'b0, current_state}.
  - 4 CNT (R): {22'b0, cnt}.
  - 5 rddata_reg, 6 wrdata_reg, 7 pk_out_reg, 8 sk_out_reg, 9 c_out_reg, 10 m_out_reg (R).
  - 11 BUSY (R): {31'b0, current_state≠IDLE}.
  - 12 VERSION (R): constant 32'h4B59_0001.
  - 13 SCRATCH (R/W): 32-bit, byte-lane-masked writes per we.
  - Any other address: reads 32'h0; writes ignored.
- Writes to read-only addresses (3–12) are ignored and do not disturb state.
- Writing 0 to START/RESTART bit 0, or with we[0]=0, produces no strobe.
- Strobes are independent of current_state; the controller decides whether to act on them.

## Timing
- Reset (rst=0 at a clock edge): rddata=0, start_pulse=0, restart_pulse=0, mode=0, SCRATCH=0. Reset overrides any simultaneous access.
- Strobes: registered; asserted for exactly the one cycle after the edge sampling the qualifying write, then 0. Back-to-back writes in consecutive cycles give a pulse in each cycle. Write to START in cycle n, RESTART in cycle n+1 → start_pulse high in n+1, restart_pulse high in n+2.
- mode and SCRATCH update at the edge sampling the write; visible on the outputs/readback from the next cycle.
- Read latency: 1 cycle. rddata is loaded at the edge sampling a read access with the value selected by addr (input mirrors sampled at that edge); it holds otherwise, including during writes.
- Read of MODE in the cycle immediately after its write returns the new value.

## Structure
- Shared package: address constants (ADDR_START … ADDR_SCRATCH), state encoding (IDLE/LOAD/PROCESS/OUTPUT), mode encoding, VERSION constant, data width 32, address width 12.
- Single module plus one natural sub-module: cs_pulse_gen (write-qualified, self-clearing one-cycle strobe), instantiated twice for start and restart.
- Read path: combinational address mux feeding one 32-bit output register.

## Test plan
- Reset: hold rst=0 two cycles with en=1, we=F, addr=0, wrdata=1 → no strobe; rddata=0, mode=0.
- Strobes: write 1 to addr 0 then addr 1 in consecutive cycles → start_pulse one cycle, restart_pulse one cycle one clock later, both otherwise 0; write 0 to addr 0 → no pulse.
- Mode: write 32'h2 to addr 2 → mode=2, read addr 2 returns 32'h2; write with we=4'b1110 → mode unchanged.
- Status mirrors: current_state=2, cnt=55, pk_out_reg=32'h3333_2222, m_out_reg=32'h9ABC_DEF0 → reads of addr 3/4/7/10 return 2, 55, 32'h3333_2222, 32'h9ABC_DEF0; addr 11 returns 1; cycle current_state 0→3 and read addr 3 each cycle, tracking with 1-cycle latency.
- Unmapped/read-only: write 32'hDEAD_BEEF to addr 3 and addr 100 → no state change; reads of addr 14 and 100 return 0; addr 12 returns 32'h4B59_0001.
- Scratch byte lanes: write 32'hAABB_CCDD we=F, then 32'h1122_3344 we=4'b0101 → read addr 13 returns 32'hAA22_CC44.
